// File: rtl/pipe_ctrl_gen.sv
// pipe_ctrl_gen: latch (S1) / read (S2) / control-issue (S3) pipeline for the RNBIP-2 core.
// Define PIPE_CTRL_HAZARD_EN to compile in the read-after-write interlock.
module pipe_ctrl_gen #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [8+DW-1:0] in_word,
  input  logic [AW-1:0]   in_pc,
  output logic            in_ready,
  input  logic            ext_stall,
  input  logic            flag,
  output logic [2:0]      rd_addr,
  output logic            ex_valid,
  output logic [7:0]      ex_opcode,
  output logic [DW-1:0]   ex_operand,
  output logic [AW-1:0]   ex_npc,
  output logic            wr_en,
  output logic [2:0]      wr_addr,
  output logic            pc_load,
  output logic            mem_rd,
  output logic            mem_wr
);

  typedef enum logic [1:0] {
    ACT_FREEZE,
    ACT_FLUSH,
    ACT_HAZARD,
    ACT_ADVANCE
  } act_e;

  typedef struct packed {
    logic pc_load;
    logic mem_rd;
    logic mem_wr;
  } strobe_t;

  logic          s1_valid;
  logic [7:0]    s1_opcode;
  logic [DW-1:0] s1_operand;
  logic [AW-1:0] s1_npc;

  logic          s2_valid;
  logic [7:0]    s2_opcode;
  logic [DW-1:0] s2_operand;
  logic [AW-1:0] s2_npc;
  logic          s2_wr;

  logic          flush;
  logic          hazard;
  act_e          act;
  strobe_t       s2_strobe;

  function automatic logic dec_wr(input logic [7:0] op);
    logic [4:0] grp;
    grp = op[7:3];
    return (op[7] && (op[6:4] != 3'b111)) ||
           (grp inside {5'b00100, 5'b01000, 5'b01010, 5'b01011, 5'b01110, 5'b01111});
  endfunction

  // Conditional classes only fire when the flag sampled on entry to S3 is set.
  function automatic strobe_t dec_strobe(input logic [7:0] op, input logic f);
    logic [4:0] grp;
    logic       jmp_u, jmp_c, call_u, call_c, ret_u, ret_c;
    strobe_t    s;
    grp    = op[7:3];
    jmp_u  = (op == 8'h03) || (op == 8'h04);
    jmp_c  = (grp == 5'b00001) || (grp == 5'b00101);
    call_u = (op == 8'h05) || (op == 8'h06);
    call_c = (grp == 5'b00110) || (grp == 5'b00111);
    ret_u  = (op == 8'h07);
    ret_c  = (grp == 5'b01001);
    s.pc_load = jmp_u || call_u || ret_u || (f && (jmp_c || call_c || ret_c));
    s.mem_wr  = call_u || (f && call_c) || (op[7:4] == 4'b0110);
    s.mem_rd  = ret_u  || (f && ret_c)  || (op[7:4] == 4'b0111);
    return s;
  endfunction

  assign rd_addr = s1_opcode[2:0];
  assign flush   = pc_load && ex_valid;

`ifdef PIPE_CTRL_HAZARD_EN
  assign hazard = s1_valid &&
                  ((s2_valid && s2_wr && (s2_opcode[2:0] == rd_addr)) ||
                   (ex_valid && wr_en && (wr_addr == rd_addr)));
`else
  assign hazard = 1'b0;
`endif

  assign in_ready = !ext_stall && !hazard && !flush;

  always_comb begin
    act = ACT_ADVANCE;
    if (ext_stall) begin
      act = ACT_FREEZE;
    end else if (flush) begin
      act = ACT_FLUSH;
    end else if (hazard) begin
      act = ACT_HAZARD;
    end
  end

  always_comb begin
    s2_strobe = dec_strobe(s2_opcode, flag);
  end

  // S1: latch stage; bubbles carry all-zero fields so rd_addr idles at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_opcode  <= '0;
      s1_operand <= '0;
      s1_npc     <= '0;
    end else begin
      case (act)
        ACT_FLUSH: begin
          s1_valid   <= 1'b0;
          s1_opcode  <= '0;
          s1_operand <= '0;
          s1_npc     <= '0;
        end
        ACT_ADVANCE: begin
          s1_valid <= in_valid;
          if (in_valid) begin
            s1_opcode  <= in_word[8+DW-1:DW];
            s1_operand <= in_word[DW-1:0];
            s1_npc     <= in_pc + 1'b1;
          end else begin
            s1_opcode  <= '0;
            s1_operand <= '0;
            s1_npc     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // S2: read stage; a hazard injects a bubble here while S1 holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s2_opcode  <= '0;
      s2_operand <= '0;
      s2_npc     <= '0;
      s2_wr      <= 1'b0;
    end else begin
      case (act)
        ACT_FLUSH, ACT_HAZARD: begin
          s2_valid   <= 1'b0;
          s2_opcode  <= '0;
          s2_operand <= '0;
          s2_npc     <= '0;
          s2_wr      <= 1'b0;
        end
        ACT_ADVANCE: begin
          s2_valid   <= s1_valid;
          s2_opcode  <= s1_opcode;
          s2_operand <= s1_operand;
          s2_npc     <= s1_npc;
          s2_wr      <= s1_valid && dec_wr(s1_opcode);
        end
        default: ;
      endcase
    end
  end

  // S3: every output is a register, zeroed whenever the slot is a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_opcode  <= '0;
      ex_operand <= '0;
      ex_npc     <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      pc_load    <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
    end else begin
      case (act)
        ACT_HAZARD, ACT_ADVANCE: begin
          ex_valid <= s2_valid;
          if (s2_valid) begin
            ex_opcode  <= s2_opcode;
            ex_operand <= s2_operand;
            ex_npc     <= s2_npc;
            wr_en      <= s2_wr;
            wr_addr    <= s2_opcode[2:0];
            pc_load    <= s2_strobe.pc_load;
            mem_rd     <= s2_strobe.mem_rd;
            mem_wr     <= s2_strobe.mem_wr;
          end else begin
            ex_opcode  <= '0;
            ex_operand <= '0;
            ex_npc     <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            pc_load    <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
          end
        end
        ACT_FLUSH: begin
          ex_valid   <= 1'b0;
          ex_opcode  <= '0;
          ex_operand <= '0;
          ex_npc     <= '0;
          wr_en      <= 1'b0;
          wr_addr    <= '0;
          pc_load    <= 1'b0;
          mem_rd     <= 1'b0;
          mem_wr     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Directed bench for pipe_ctrl_gen: an instruction-level pipeline model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_pipe_ctrl_gen;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid;
  logic [8+DW-1:0] in_word;
  logic [AW-1:0]   in_pc;
  logic            in_ready;
  logic            ext_stall;
  logic            flag;
  logic [2:0]      rd_addr;
  logic            ex_valid;
  logic [7:0]      ex_opcode;
  logic [DW-1:0]   ex_operand;
  logic [AW-1:0]   ex_npc;
  logic            wr_en;
  logic [2:0]      wr_addr;
  logic            pc_load;
  logic            mem_rd;
  logic            mem_wr;

  pipe_ctrl_gen #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .in_pc(in_pc),
    .in_ready(in_ready), .ext_stall(ext_stall), .flag(flag), .rd_addr(rd_addr),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_operand(ex_operand), .ex_npc(ex_npc),
    .wr_en(wr_en), .wr_addr(wr_addr), .pc_load(pc_load), .mem_rd(mem_rd), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit          v;
    bit [7:0]    op;
    bit [DW-1:0] opd;
    bit [AW-1:0] pc;
  } ins_t;

  ins_t mdl [1:3];
  bit   m_flag;
  int   tests = 0;
  int   fails = 0;
  bit   chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit rng(input bit [7:0] op, input int lo, input int hi);
    return (int'(op) >= lo) && (int'(op) <= hi);
  endfunction

  function automatic bit m_writes(input bit [7:0] op);
    return rng(op, 'h80, 'hEF) || rng(op, 'h20, 'h27) || rng(op, 'h40, 'h47) ||
           rng(op, 'h50, 'h5F) || rng(op, 'h70, 'h7F);
  endfunction

  function automatic bit m_branch(input bit [7:0] op, input bit f);
    return rng(op, 3, 7) ||
           (f && (rng(op, 'h08, 'h0F) || rng(op, 'h28, 'h3F) || rng(op, 'h48, 'h4F)));
  endfunction

  function automatic bit m_memwr(input bit [7:0] op, input bit f);
    return rng(op, 5, 6) || (f && rng(op, 'h30, 'h3F)) || rng(op, 'h60, 'h6F);
  endfunction

  function automatic bit m_memrd(input bit [7:0] op, input bit f);
    return (op == 8'h07) || (f && rng(op, 'h48, 'h4F)) || rng(op, 'h70, 'h7F);
  endfunction

  function automatic bit e_pc_load();
    return mdl[3].v && m_branch(mdl[3].op, m_flag);
  endfunction

  function automatic bit [AW-1:0] e_npc();
    bit [AW-1:0] n;
    n = mdl[3].pc + 1'b1;
    return mdl[3].v ? n : '0;
  endfunction

  function automatic bit m_hazard();
    bit h;
    h = 1'b0;
`ifdef PIPE_CTRL_HAZARD_EN
    if (mdl[1].v) begin
      for (int s = 2; s <= 3; s++) begin
        if (mdl[s].v && m_writes(mdl[s].op) && (mdl[s].op[2:0] == mdl[1].op[2:0])) h = 1'b1;
      end
    end
`endif
    return h;
  endfunction

  function automatic bit m_ready(input bit st);
    return !st && !m_hazard() && !e_pc_load();
  endfunction

  task automatic m_clear();
    for (int s = 1; s <= 3; s++) mdl[s] = '0;
    m_flag = 1'b0;
  endtask

  task automatic m_step(input bit v, input bit [7:0] op, input bit [DW-1:0] opd,
                        input bit [AW-1:0] pc, input bit st, input bit fl);
    if (rst) begin
      m_clear();
    end else if (st) begin
      // whole pipe frozen
    end else if (e_pc_load()) begin
      m_clear();
    end else if (m_hazard()) begin
      mdl[3] = mdl[2];
      m_flag = fl;
      mdl[2] = '0;
    end else begin
      mdl[3] = mdl[2];
      m_flag = fl;
      mdl[2] = mdl[1];
      mdl[1] = v ? {1'b1, op, opd, pc} : '0;
    end
  endtask

  task automatic tick(input bit v, input bit [7:0] op, input bit [DW-1:0] opd,
                      input bit [AW-1:0] pc, input bit st, input bit fl);
    in_valid  = v;
    in_word   = {op, opd};
    in_pc     = pc;
    ext_stall = st;
    flag      = fl;
    @(posedge clk);
    m_step(v, op, opd, pc, st, fl);
    #1;
  endtask

  task automatic idle(input int n, input bit fl);
    repeat (n) tick(1'b0, 8'h00, '0, '0, 1'b0, fl);
  endtask

  task automatic feed(input bit [7:0] op, input bit [DW-1:0] opd, input bit [AW-1:0] pc,
                      input bit fl);
    bit acc;
    int tries;
    tries = 0;
    do begin
      acc = m_ready(1'b0);
      tick(1'b1, op, opd, pc, 1'b0, fl);
      tries++;
    end while (!acc && tries < 20);
    if (!acc) chk("feed_accept_timeout", 32'(0), 32'(1));
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ex_valid",   32'(ex_valid),   32'(mdl[3].v));
      chk("ex_opcode",  32'(ex_opcode),  32'(mdl[3].v ? mdl[3].op : 8'h00));
      chk("ex_operand", 32'(ex_operand), 32'(mdl[3].v ? mdl[3].opd : '0));
      chk("ex_npc",     32'(ex_npc),     32'(e_npc()));
      chk("wr_en",      32'(wr_en),      32'(mdl[3].v && m_writes(mdl[3].op)));
      chk("wr_addr",    32'(wr_addr),    32'(mdl[3].v ? mdl[3].op[2:0] : 3'd0));
      chk("pc_load",    32'(pc_load),    32'(e_pc_load()));
      chk("mem_rd",     32'(mem_rd),     32'(mdl[3].v && m_memrd(mdl[3].op, m_flag)));
      chk("mem_wr",     32'(mem_wr),     32'(mdl[3].v && m_memwr(mdl[3].op, m_flag)));
      chk("in_ready",   32'(in_ready),   32'(m_ready(ext_stall)));
      if (mdl[1].v) chk("rd_addr", 32'(rd_addr), 32'(mdl[1].op[2:0]));
    end
  end

  bit [7:0] sweep_ops [16] = '{8'h20, 8'h60, 8'h70, 8'h30, 8'h48, 8'h9A, 8'h28, 8'h07,
                               8'h55, 8'h00, 8'hF3, 8'h3C, 8'h12, 8'hE1, 8'h06, 8'h71};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; in_word = '0; in_pc = '0; ext_stall = 1'b0; flag = 1'b0;
    m_clear();
    #2 rst = 1'b1;
    chk_on = 1'b1;
    #1;
    chk("rst_ex_valid", 32'(ex_valid), 32'(0));
    chk("rst_pc_load",  32'(pc_load),  32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // plain stream, three-edge latency
    feed(8'h80, 8'h11, 8'h00, 1'b0);
    feed(8'h01, 8'h22, 8'h01, 1'b0);
    feed(8'h02, 8'h33, 8'h02, 1'b0);
    chk("t1_op80", 32'(ex_opcode), 32'h80);
    chk("t1_wr80", 32'(wr_en), 32'(1));
    chk("t1_npc",  32'(ex_npc), 32'h01);
    idle(1, 1'b0);
    chk("t1_op01", 32'(ex_opcode), 32'h01);
    chk("t1_wr01", 32'(wr_en), 32'(0));
    idle(1, 1'b0);
    chk("t1_op02", 32'(ex_opcode), 32'h02);
    chk("t1_model_wr02", 32'(m_writes(mdl[3].op)), 32'(0));

    // unconditional jump flushes the two younger words
    idle(3, 1'b0);
    feed(8'h04, 8'h00, 8'h10, 1'b0);
    feed(8'h81, 8'h01, 8'h11, 1'b0);
    feed(8'h82, 8'h02, 8'h12, 1'b0);
    chk("t2_pc_load", 32'(pc_load), 32'(1));
    chk("t2_npc",     32'(ex_npc), 32'h11);
    chk("t2_ready",   32'(in_ready), 32'(0));
    chk("t2_model_pc_load", 32'(e_pc_load()), 32'(1));
    idle(1, 1'b0);
    chk("t2_pc_load_drop", 32'(pc_load), 32'(0));
    chk("t2_bubble1", 32'(ex_valid), 32'(0));
    idle(1, 1'b0);
    chk("t2_bubble2", 32'(ex_valid), 32'(0));
    idle(2, 1'b0);

    // conditional jump, flag clear then set
    feed(8'h08, 8'h00, 8'h20, 1'b0);
    idle(2, 1'b0);
    chk("t3_nf_valid", 32'(ex_valid), 32'(1));
    chk("t3_nf_pc_load", 32'(pc_load), 32'(0));
    idle(3, 1'b0);
    feed(8'h08, 8'h00, 8'h21, 1'b1);
    idle(2, 1'b1);
    chk("t3_f_pc_load", 32'(pc_load), 32'(1));
    chk("t3_f_ready", 32'(in_ready), 32'(0));
    idle(1, 1'b1);
    chk("t3_f_flushed", 32'(ex_valid), 32'(0));
    idle(3, 1'b0);

    // RAW: producer in S2 when consumer enters S1
    feed(8'h8B, 8'h00, 8'h30, 1'b0);
    feed(8'h43, 8'h00, 8'h31, 1'b0);
`ifdef PIPE_CTRL_HAZARD_EN
    chk("t4_ready_hz", 32'(in_ready), 32'(0));
`else
    chk("t4_ready_nohz", 32'(in_ready), 32'(1));
`endif
    idle(1, 1'b0);
    chk("t4_op8b", 32'(ex_opcode), 32'h8B);
`ifdef PIPE_CTRL_HAZARD_EN
    idle(1, 1'b0);
    chk("t4_gap1", 32'(ex_valid), 32'(0));
    idle(1, 1'b0);
    chk("t4_gap2", 32'(ex_valid), 32'(0));
`endif
    idle(1, 1'b0);
    chk("t4_op43", 32'(ex_opcode), 32'h43);
    chk("t4_v43", 32'(ex_valid), 32'(1));
    idle(3, 1'b0);

    // RAW: producer already in S3, one bubble
    feed(8'h8B, 8'h00, 8'h40, 1'b0);
    feed(8'h00, 8'h00, 8'h41, 1'b0);
    feed(8'h43, 8'h00, 8'h42, 1'b0);
    idle(1, 1'b0);
    chk("t4b_op00", 32'(ex_opcode), 32'h00);
    chk("t4b_v00", 32'(ex_valid), 32'(1));
`ifdef PIPE_CTRL_HAZARD_EN
    idle(1, 1'b0);
    chk("t4b_gap", 32'(ex_valid), 32'(0));
`endif
    idle(1, 1'b0);
    chk("t4b_op43", 32'(ex_opcode), 32'h43);
    idle(3, 1'b0);

    // ext_stall holds a pending call
    feed(8'h05, 8'h00, 8'h50, 1'b0);
    feed(8'h81, 8'h00, 8'h51, 1'b0);
    feed(8'h82, 8'h00, 8'h52, 1'b0);
    chk("t5_pc_load0", 32'(pc_load), 32'(1));
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 8'h83, 8'h00, 8'h53, 1'b1, 1'b0);
      chk("t5_stall_pc_load", 32'(pc_load), 32'(1));
      chk("t5_stall_mem_wr", 32'(mem_wr), 32'(1));
      chk("t5_stall_op", 32'(ex_opcode), 32'h05);
      chk("t5_stall_ready", 32'(in_ready), 32'(0));
    end
    idle(1, 1'b0);
    chk("t5_flush_valid", 32'(ex_valid), 32'(0));
    chk("t5_flush_mem_wr", 32'(mem_wr), 32'(0));
    idle(3, 1'b0);

    // PC wrap
    feed(8'h00, 8'h00, 8'hFF, 1'b0);
    idle(2, 1'b0);
    chk("t6_npc_wrap", 32'(ex_npc), 32'h00);
    chk("t6_valid", 32'(ex_valid), 32'(1));
    chk("t6_model_npc", 32'(e_npc()), 32'h00);
    idle(2, 1'b0);

    // opcode class sweep with alternating flag
    for (int i = 0; i < 16; i++) feed(sweep_ops[i], 8'(i * 17), 8'(8'h80 + i), i[0]);
    idle(6, 1'b0);

    // asynchronous reset mid-stream
    feed(8'h81, 8'h01, 8'h60, 1'b0);
    feed(8'h92, 8'h02, 8'h61, 1'b0);
    feed(8'hA3, 8'h03, 8'h62, 1'b0);
    chk("t7_pre_wr", 32'(wr_en), 32'(1));
    #2 rst = 1'b1;
    m_clear();
    #1;
    chk("t7_rst_valid", 32'(ex_valid), 32'(0));
    chk("t7_rst_wr", 32'(wr_en), 32'(0));
    chk("t7_rst_op", 32'(ex_opcode), 32'(0));
    chk("t7_rst_npc", 32'(ex_npc), 32'(0));
    idle(1, 1'b0);
    rst = 1'b0;
    feed(8'h84, 8'h04, 8'h70, 1'b0);
    chk("t7_e1", 32'(ex_valid), 32'(0));
    idle(1, 1'b0);
    chk("t7_e2", 32'(ex_valid), 32'(0));
    idle(1, 1'b0);
    chk("t7_e3", 32'(ex_valid), 32'(1));
    chk("t7_e3_op", 32'(ex_opcode), 32'h84);
    idle(2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_gen.md
# pipe_ctrl_gen

Parametrised three-stage control pipeline for the RNBIP-2 core: latch (S1), read (S2) and control-issue (S3). It adds valid bits, external stall, branch flush, PC+1 generation and an optional read-after-write interlock. It accepts instruction words from fetch and drives registered control strobes to the register file, PC and data memory. Opcode stays 8 bits with the register field in opcode[2:0]; operand and PC widths are generic.

## Interface
- DW, 8: operand width; instruction word is {opcode[7:0], operand[DW-1:0]}
- AW, 8: PC width
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch presents a word
- in_word  in  8+DW  instruction word
- in_pc  in  AW  address of in_word
- in_ready  out  1  word accepted on this edge when in_valid && in_ready
- ext_stall  in  1  global freeze (memory wait)
- flag  in  1  ALU condition flag, sampled on the S2->S3 transfer
- rd_addr  out  3  S1 opcode[2:0], combinational, register-file read address
- ex_valid  out  1  S3 holds a real instruction
- ex_opcode  out  8  S3 opcode
- ex_operand  out  DW  S3 operand
- ex_npc  out  AW  S3 PC+1, wraps mod 2^AW
- wr_en  out  1  register write
- wr_addr  out  3  register write address (S3 opcode[2:0])
- pc_load  out  1  taken jump, call or return
- mem_rd  out  1  data memory read
- mem_wr  out  1  data memory write

## Operation
- Stages S1, S2 and S3 each hold valid, opcode, operand, npc. S2 and S3 also hold the decoded wr_en class. S3 also holds the sampled flag.
- All S3 outputs are registered and are forced to 0 when ex_valid=0.
- Decode classes (op = opcode):
  - Unconditional jump: 0x03, 0x04 -> pc_load.
  - Conditional jump: op[7:3] = 00001 or 00101 -> pc_load if flag.
  - Call: 0x05, 0x06 unconditional; op[7:3] = 00110 or 00111 conditional -> pc_load, mem_wr.
  - Return: 0x07 unconditional; op[7:3] = 01001 conditional -> pc_load, mem_rd.
  - Register write: op[7:4] in 0x8..0xE, or op[7:3] in {00100, 01000, 01010, 01011, 01110, 01111} -> wr_en.
  - Memory read: op[7:4] = 0111 -> mem_rd.
  - Memory write: op[7:4] = 0110 -> mem_wr.
  - All other opcodes -> no strobes (NOP behaviour).
- Flush: when pc_load=1 with ex_valid=1, S1 and S2 valid clear on the next edge, in_ready=0 that cycle, and the following S3 slot is a bubble. As a result, pc_load is high for at most one cycle per branch unless frozen.
- Hazard (compiled in, see Configuration):
  - Condition: S1 valid && ((S2 valid && S2 wr_en && S2 reg == rd_addr) || (ex_valid && wr_en && wr_addr == rd_addr)).
  - Effect: S1 holds, S2 loads a bubble, S3 advances, in_ready=0.
- in_ready = !ext_stall && !hazard && !(pc_load && ex_valid).
- Priority: rst > ext_stall > flush > hazard > normal advance.
- ext_stall freezes every stage and every output, including a pending pc_load. The flush is deferred until the stall drops.

## Timing
- Reset values: all valid bits 0, all stage registers 0, all outputs 0. in_ready = 1 while rst=0 and no stall.
- Reset mid-operation: state clears immediately (asynchronous). In-flight instructions are lost and no strobe survives.
- Latency: a word accepted at edge k sits in S1 after k, in S2 after k+1, and drives the S3 outputs after k+2.
- Throughput: one instruction per cycle with no stall, hazard or flush.
- A hazard costs 1 bubble when the producer is in S3 and 2 bubbles when it is in S2.
- in_valid=0 with in_ready=1 loads a bubble into S1.

## Configuration
- PIPE_CTRL_HAZARD_EN defined: the RAW interlock above is active.
- Not defined: the hazard term is constant 0 and software must insert NOPs. All other behaviour is identical.

## Test plan
- Reset, then stream 0x80 (ADA r0), 0x01, 0x02 with no stalls -> after edges 3, 4, 5: ex_opcode = 0x80 / 0x01 / 0x02, wr_en = 1 / 0 / 0 (0x01 is not a register-write class).
- JUA 0x04 at pc=0x10, then two more words -> pc_load=1 and ex_npc=0x11 for one cycle; the two younger words never reach ex_valid=1; in_ready=0 in the pc_load cycle.
- Conditional jump 0x08: flag=0 -> pc_load=0; repeat with flag=1 -> pc_load=1 and flush.
- Hazard macro on: 0x8B (writes r3), then 0x43 (reads r3) -> 2-cycle gap between their ex_valid pulses. Macro off -> back-to-back pulses.
- Hold ext_stall=1 for 3 cycles while S3 holds 0x05 (call) -> pc_load and mem_wr stay 1 throughout; flush occurs only after ext_stall=0.
- in_pc = 2^AW-1 (0xFF for AW=8) -> ex_npc = 0. Assert rst mid-stream -> all outputs 0 immediately, first ex_valid 3 edges after the next accepted word.
